// File: rtl/spi_flash_loader_if.sv
// Memory write request bus: strobe, byte mask, data and byte address.
// Used both for the CPU request into the loader and the request out to memory decode.
interface spi_flash_loader_if;
    logic        write;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] addr;

    modport master (output write, wmask, wdata, addr);
    modport slave  (input  write, wmask, wdata, addr);
endinterface

// File: rtl/spi_flash_loader.sv
// Boot copy engine: streams a flash region into main memory with SPI READ (03h), else passes CPU/GPIO through.
// 64*CLK_DIV cycles per word after a 64*CLK_DIV command phase; the CPU is stalled via cpu_hold while busy.
module spi_flash_loader #(
    parameter logic [23:0] FLASH_ADDR = 24'h10_0000,
    parameter logic [31:0] DEST_ADDR  = 32'h0000_0000,
    parameter int unsigned WORD_COUNT = 16384,
    parameter int unsigned CLK_DIV    = 1,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               cpu_hold,
    spi_flash_loader_if.slave  cpu_mem,
    spi_flash_loader_if.master mem,
    input  logic               gpio_cs,
    input  logic               gpio_clk,
    input  logic               gpio_do,
    output logic               gpio_di,
    output logic               spics,
    output logic               spiclk,
    output logic               spido,
    input  logic               spidi
);
    typedef enum logic [2:0] {IDLE, CMD, DATA, WR, FIN} state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [31:0] LAST_IDX = 32'(WORD_COUNT - 1);
    localparam bit          ZERO_LEN = (WORD_COUNT == 0);

    state_t      state, state_nxt;
    logic        pend;
    logic        done_q;
    logic [31:0] idx;
    logic [31:0] sr;
    logic [15:0] div_cnt;
    logic [4:0]  bit_cnt;
    logic        sclk;
    logic        go, bit_end;
    logic        e_cs, e_clk, e_do, e_write;

    assign go      = (state == IDLE) && (pend || start);
    assign bit_end = sclk && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (go && !ZERO_LEN) state_nxt = CMD;
            CMD:     if (bit_end && bit_cnt == 5'd31) state_nxt = DATA;
            DATA:    if (bit_end && bit_cnt == 5'd31) state_nxt = WR;
            WR:      state_nxt = (idx == LAST_IDX) ? FIN : DATA;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One shift register serves both directions: command out in CMD, flash bytes in during DATA.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend    <= AUTO_START;
            done_q  <= 1'b0;
            idx     <= '0;
            sr      <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
        end else begin
            pend <= 1'b0;
            if (go) begin
                done_q  <= ZERO_LEN;
                idx     <= '0;
                sr      <= {8'h03, FLASH_ADDR};
                div_cnt <= '0;
                bit_cnt <= '0;
                sclk    <= 1'b0;
            end else begin
                if (state == FIN) done_q <= 1'b1;
                if (state == CMD || state == DATA || state == WR) begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        sr      <= {sr[30:0], (state == DATA) ? spidi : 1'b0};
                    end
                    if (state == WR) idx <= idx + 32'd1;
                end
            end
        end
    end

    always_comb begin
        e_cs    = 1'b1;
        e_clk   = 1'b0;
        e_do    = 1'b0;
        e_write = 1'b0;
        unique case (state)
            CMD: begin
                e_cs  = 1'b0;
                e_clk = sclk;
                e_do  = sr[31];
            end
            DATA: begin
                e_cs  = 1'b0;
                e_clk = sclk;
            end
            WR: begin
                e_cs    = 1'b0;
                e_clk   = sclk;
                e_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy     = (state != IDLE) || pend;
    assign cpu_hold = busy;
    assign done     = done_q;
    assign gpio_di  = spidi;

    // Flash sends byte 0 first; it belongs in the low byte of the word.
    assign mem.write = busy ? e_write : cpu_mem.write;
    assign mem.wmask = busy ? 4'b1111 : cpu_mem.wmask;
    assign mem.wdata = busy ? {sr[7:0], sr[15:8], sr[23:16], sr[31:24]} : cpu_mem.wdata;
    assign mem.addr  = busy ? DEST_ADDR + {idx[29:0], 2'b00} : cpu_mem.addr;

    assign spics  = busy ? e_cs  : gpio_cs;
    assign spiclk = busy ? e_clk : gpio_clk;
    assign spido  = busy ? e_do  : gpio_do;
endmodule

// File: tb/tb_spi_flash_loader.sv
// Directed bench for spi_flash_loader: three instances (basic/auto-start, zero-length, CLK_DIV=3)
// each attached to a behavioural SPI flash that returns bytes 11 22 33 ... from the READ address.
module tb_spi_flash_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, start_a, start_z, start_s;
    logic gpio_cs, gpio_clk, gpio_do, idle_di, idle_mode;
    logic busy_a, done_a, hold_a, gdi_a, spics_a, spiclk_a, spido_a, spidi_a;
    logic busy_z, done_z, hold_z, gdi_z, spics_z, spiclk_z, spido_z, spidi_z;
    logic busy_s, done_s, hold_s, gdi_s, spics_s, spiclk_s, spido_s, spidi_s;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    always @(posedge clk) cyc <= cyc + 1;

    spi_flash_loader_if cpu_if ();
    spi_flash_loader_if mem_a ();
    spi_flash_loader_if mem_z ();
    spi_flash_loader_if mem_s ();

    spi_flash_loader #(.FLASH_ADDR(24'h10_0000), .DEST_ADDR(32'h100), .WORD_COUNT(2),
                       .CLK_DIV(1), .AUTO_START(1'b1)) u_a (
        .clk(clk), .rstn(rstn), .start(start_a), .busy(busy_a), .done(done_a), .cpu_hold(hold_a),
        .cpu_mem(cpu_if), .mem(mem_a), .gpio_cs(gpio_cs), .gpio_clk(gpio_clk), .gpio_do(gpio_do),
        .gpio_di(gdi_a), .spics(spics_a), .spiclk(spiclk_a), .spido(spido_a), .spidi(spidi_a));

    spi_flash_loader #(.FLASH_ADDR(24'h10_0000), .DEST_ADDR(32'h100), .WORD_COUNT(0),
                       .CLK_DIV(1), .AUTO_START(1'b0)) u_z (
        .clk(clk), .rstn(rstn), .start(start_z), .busy(busy_z), .done(done_z), .cpu_hold(hold_z),
        .cpu_mem(cpu_if), .mem(mem_z), .gpio_cs(gpio_cs), .gpio_clk(gpio_clk), .gpio_do(gpio_do),
        .gpio_di(gdi_z), .spics(spics_z), .spiclk(spiclk_z), .spido(spido_z), .spidi(spidi_z));

    spi_flash_loader #(.FLASH_ADDR(24'h10_0000), .DEST_ADDR(32'h100), .WORD_COUNT(2),
                       .CLK_DIV(3), .AUTO_START(1'b0)) u_s (
        .clk(clk), .rstn(rstn), .start(start_s), .busy(busy_s), .done(done_s), .cpu_hold(hold_s),
        .cpu_mem(cpu_if), .mem(mem_s), .gpio_cs(gpio_cs), .gpio_clk(gpio_clk), .gpio_do(gpio_do),
        .gpio_di(gdi_s), .spics(spics_s), .spiclk(spiclk_s), .spido(spido_s), .spidi(spidi_s));

    wire [2:0]       cs_v  = {spics_s, spics_z, spics_a};
    wire [2:0]       sck_v = {spiclk_s, spiclk_z, spiclk_a};
    wire [2:0]       sdo_v = {spido_s, spido_z, spido_a};
    wire [2:0]       wr_v  = {mem_s.write, mem_z.write, mem_a.write};
    wire [2:0][31:0] ma_v  = {mem_s.addr, mem_z.addr, mem_a.addr};
    wire [2:0][31:0] md_v  = {mem_s.wdata, mem_z.wdata, mem_a.wdata};
    wire [2:0][3:0]  mm_v  = {mem_s.wmask, mem_z.wmask, mem_a.wmask};

    function automatic logic [7:0] byte_at(input int i);
        return 8'((i + 1) * 17);
    endfunction

    // Flash model: samples the SPI pins mid-cycle. The data bit is correct only in the last
    // cycle of each high phase and inverted elsewhere, so an early sample reads wrong data.
    for (genvar g = 0; g < 3; g++) begin : g_fl
        localparam int DV = (g == 2) ? 3 : 1;
        int          nrise = 0, hcnt = 0, run = 0, bad = 0, nph = 0, wn = 0, csfall = 0, bi = 0;
        logic        run_ok = 1'b1, cs_prev = 1'b1, sck_prev = 1'b0, di = 1'b0;
        logic [7:0]  bt = 8'h00;
        logic [31:0] cmd = 32'h0;
        logic [31:0] wa [256];
        logic [31:0] wd [256];
        logic [3:0]  wm [256];
        int          wc [256];

        always @(negedge clk) begin
            if (cs_v[g]) begin
                nrise = 0; hcnt = 0; run = 0; run_ok = 1'b1; di = 1'b0;
            end else begin
                if (cs_prev) csfall++;
                if (sck_v[g] != sck_prev) begin
                    if (run_ok && run != DV) bad++;
                    nph++;
                    run = 1;
                end else begin
                    run++;
                end
                if (sck_v[g] && !sck_prev) begin
                    nrise++;
                    hcnt = 0;
                    if (nrise <= 32) cmd = {cmd[30:0], sdo_v[g]};
                end
                if (sck_v[g]) hcnt++;
                if (sck_v[g] && nrise > 32) begin
                    bi = nrise - 33;
                    bt = byte_at(bi / 8);
                    di = (hcnt == DV) ? bt[7 - (bi % 8)] : ~bt[7 - (bi % 8)];
                end else begin
                    di = 1'b0;
                end
            end
            if (wr_v[g] && wn < 256) begin
                wa[wn] = ma_v[g]; wd[wn] = md_v[g]; wm[wn] = mm_v[g]; wc[wn] = cyc;
                wn++;
            end
            cs_prev  = cs_v[g];
            sck_prev = sck_v[g];
        end
    end

    assign spidi_a = idle_mode ? idle_di : g_fl[0].di;
    assign spidi_z = idle_mode ? idle_di : g_fl[1].di;
    assign spidi_s = idle_mode ? idle_di : g_fl[2].di;

    logic z_busy_seen = 1'b0;
    always @(negedge clk) if (busy_z) z_busy_seen <= 1'b1;

    typedef struct {
        logic        cw;  logic [3:0] cm; logic [31:0] cd; logic [31:0] ca;
        logic        gcs; logic gclk; logic gdo; logic idi;
        logic        ew;  logic [3:0] em; logic [31:0] ed; logic [31:0] ea;
        logic        ecs; logic eclk; logic edo; logic edi;
    } vec_t;
    vec_t tv [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int na, fa, ns, fs, bs, ps, stamp;

    initial begin
        tv[0] = '{1'b1, 4'hF, 32'hDEADBEEF, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b1, 4'hF, 32'hDEADBEEF, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[1] = '{1'b0, 4'h3, 32'h1234_5678, 32'h0000_0204, 1'b0, 1'b1, 1'b1, 1'b0,
                  1'b0, 4'h3, 32'h1234_5678, 32'h0000_0204, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[2] = '{1'b1, 4'h8, 32'hCAFE_F00D, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b1,
                  1'b1, 4'h8, 32'hCAFE_F00D, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b1};
        tv[3] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0,
                  1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};

        rstn = 1'b0; start_a = 1'b0; start_z = 1'b0; start_s = 1'b0;
        gpio_cs = 1'b1; gpio_clk = 1'b0; gpio_do = 1'b0; idle_di = 1'b0; idle_mode = 1'b0;
        cpu_if.write = 1'b1; cpu_if.wmask = 4'hF; cpu_if.wdata = 32'hDEADBEEF; cpu_if.addr = 32'h200;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy_a", busy_a, 1'b1);
        chk("rst_hold_a", hold_a, 1'b1);
        chk("rst_done_a", done_a, 1'b0);
        chk("rst_pins_a", {spics_a, spiclk_a, spido_a}, 3'b100);
        chk("rst_memwr_a", mem_a.write, 1'b0);
        chk("rst_busy_s", busy_s, 1'b0);
        gpio_cs = 1'b0; #1;
        chk("rst_pass_cs_s", spics_s, 1'b0);
        chk("rst_eng_cs_a", spics_a, 1'b1);
        chk("rst_pass_wr_s", {mem_s.write, mem_s.addr}, {1'b1, 32'h200});
        gpio_cs = 1'b1;

        // Auto-start basic copy with a CPU write presented during the copy
        @(negedge clk);
        na = g_fl[0].wn; fa = g_fl[0].csfall;
        rstn = 1'b1;
        @(posedge clk); #1; stamp = cyc;
        chk("a_c1_busy_cs", {busy_a, hold_a, spics_a}, 3'b110);
        chk("a_c1_memwr", mem_a.write, 1'b0);
        repeat (150) @(negedge clk);
        cpu_if.write = 1'b0;
        for (int i = 0; i < 2000 && !done_a; i++) @(negedge clk);
        chk("a_done", done_a, 1'b1);
        chk("a_idle_busy_cs", {busy_a, spics_a}, 2'b01);
        chk("a_cmd", g_fl[0].cmd, 32'h0310_0000);
        chk("a_nwr", g_fl[0].wn - na, 2);
        chk("a_w0", {g_fl[0].wm[na], g_fl[0].wa[na], g_fl[0].wd[na]}, {4'hF, 32'h100, 32'h4433_2211});
        chk("a_w1", {g_fl[0].wm[na+1], g_fl[0].wa[na+1], g_fl[0].wd[na+1]}, {4'hF, 32'h104, 32'h8877_6655});
        chk("a_last_wr_cycle", g_fl[0].wc[na+1] - stamp, 192);
        chk("a_cs_windows", g_fl[0].csfall - fa, 1);

        // Idle pass-through, combinational in the same cycle
        idle_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cpu_if.write = tv[i].cw; cpu_if.wmask = tv[i].cm; cpu_if.wdata = tv[i].cd; cpu_if.addr = tv[i].ca;
            gpio_cs = tv[i].gcs; gpio_clk = tv[i].gclk; gpio_do = tv[i].gdo; idle_di = tv[i].idi;
            #1;
            chk($sformatf("pt%0d_mem", i), {mem_a.write, mem_a.wmask, mem_a.wdata, mem_a.addr},
                {tv[i].ew, tv[i].em, tv[i].ed, tv[i].ea});
            chk($sformatf("pt%0d_pins", i), {spics_a, spiclk_a, spido_a}, {tv[i].ecs, tv[i].eclk, tv[i].edo});
            chk($sformatf("pt%0d_di", i), {gdi_a, gdi_z, gdi_s}, {3{tv[i].edi}});
            chk($sformatf("pt%0d_hold", i), hold_a, 1'b0);
        end
        @(negedge clk);
        cpu_if.write = 1'b0; gpio_cs = 1'b1; gpio_clk = 1'b0; gpio_do = 1'b0; idle_mode = 1'b0;

        // Zero-length copy
        @(negedge clk);
        chk("z_done_before", done_z, 1'b0);
        start_z = 1'b1;
        @(posedge clk); #1; start_z = 1'b0;
        chk("z_done", done_z, 1'b1);
        chk("z_busy_hold", {busy_z, hold_z}, 2'b00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            gpio_cs = i[0];
            #1;
            chk("z_cs_follow", spics_z, gpio_cs);
        end
        gpio_cs = 1'b1;
        chk("z_busy_never", z_busy_seen, 1'b0);

        // Slow SPI clock
        @(negedge clk);
        ns = g_fl[2].wn; fs = g_fl[2].csfall; bs = g_fl[2].bad; ps = g_fl[2].nph;
        start_s = 1'b1;
        @(posedge clk); #1; start_s = 1'b0; stamp = cyc;
        chk("s_c1_busy_cs", {busy_s, hold_s, spics_s}, 3'b110);
        for (int i = 0; i < 5000 && !done_s; i++) @(negedge clk);
        chk("s_done", {done_s, busy_s, spics_s}, 3'b101);
        chk("s_cmd", g_fl[2].cmd, 32'h0310_0000);
        chk("s_nwr", g_fl[2].wn - ns, 2);
        chk("s_w0", {g_fl[2].wa[ns], g_fl[2].wd[ns]}, {32'h100, 32'h4433_2211});
        chk("s_w1", {g_fl[2].wa[ns+1], g_fl[2].wd[ns+1]}, {32'h104, 32'h8877_6655});
        chk("s_last_wr_cycle", g_fl[2].wc[ns+1] - stamp, 576);
        chk("s_phase_len_bad", g_fl[2].bad - bs, 0);
        chk("s_phases_seen", (g_fl[2].nph - ps) > 100, 1'b1);
        chk("s_cs_windows", g_fl[2].csfall - fs, 1);

        // Start pulsed again in the middle of DATA
        @(negedge clk);
        na = g_fl[0].wn; fa = g_fl[0].csfall;
        start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        chk("i_done_cleared", {done_a, busy_a}, 2'b01);
        repeat (100) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 2000 && !done_a; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("i_done_idle", {done_a, busy_a}, 2'b10);
        chk("i_nwr", g_fl[0].wn - na, 2);
        chk("i_w1", {g_fl[0].wa[na+1], g_fl[0].wd[na+1]}, {32'h104, 32'h8877_6655});
        chk("i_cs_windows", g_fl[0].csfall - fa, 1);

        // Reset in the middle of the second word, then auto-restart
        @(negedge clk);
        na = g_fl[0].wn;
        start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        for (int i = 0; i < 1000 && (g_fl[0].wn - na) < 1; i++) @(negedge clk);
        chk("r_first_wr", g_fl[0].wn - na, 1);
        repeat (20) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("r_cs_async", spics_a, 1'b1);
        chk("r_wr_in_rst", {mem_a.write, busy_a}, 2'b01);
        repeat (5) @(negedge clk);
        chk("r_no_wr_in_rst", g_fl[0].wn - na, 1);
        rstn = 1'b1;
        for (int i = 0; i < 1000 && (g_fl[0].wn - na) < 2; i++) @(negedge clk);
        chk("r_restart_w0", {g_fl[0].wa[na+1], g_fl[0].wd[na+1]}, {32'h100, 32'h4433_2211});
        for (int i = 0; i < 2000 && !done_a; i++) @(negedge clk);
        chk("r_done", done_a, 1'b1);
        chk("r_total_wr", g_fl[0].wn - na, 3);
        chk("r_restart_w1", {g_fl[0].wa[na+2], g_fl[0].wd[na+2]}, {32'h104, 32'h8877_6655});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
